spi_frame_rx: RTL and testbench



---
 rtl/spi_pkg.sv | 38 +++
 rtl/spi_frame_rx_if.sv | 48 ++++
 rtl/sync_edge.sv | 42 ++++
 rtl/spi_frame_rx.sv | 222 ++++++++++++++++++++++
 tb/tb_spi_frame_rx.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI frame receiver and its register bank:
// frame geometry, register address map, receiver FSM state encoding and a
// saturating-counter helper.
// No ports (package).
// ---------------------------------------------------------------------------
package spi_pkg;

  localparam int FRAME_BITS = 16;  // 1 R/W + 7 address + 8 data
  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;

  // Register bank address map
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = 7'd0;
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = 7'd1;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_LO = 7'd2;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_HI = 7'd3;
  localparam logic [ADDR_W-1:0] ADDR_DUTY      = 7'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } spi_state_e;

  // 8-bit increment that sticks at 255 instead of wrapping
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    logic [7:0] result;
    if (value == 8'hFF) begin
      result = value;
    end else begin
      result = value + 8'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/spi_frame_rx_if.sv
// ---------------------------------------------------------------------------
// spi_frame_rx_if
// Bundles the raw SPI pins and the register-write strobe bus of spi_frame_rx.
//   sclk, copi, ncs     : raw asynchronous SPI pins (into the receiver)
//   wr_valid            : one-cycle register write strobe
//   wr_addr / wr_data   : write address / data, held between strobes
//   busy                : frame in progress
//   frame_err/err_count : abort pulse and saturating abort count
//                         (only when SPI_FRAME_ERR_EN is defined)
// Modports: slave = receiver side, master = pin driver / bank side.
// Optional feature macro: SPI_FRAME_ERR_EN.
// ---------------------------------------------------------------------------
interface spi_frame_rx_if;
  import spi_pkg::*;

  logic              sclk;
  logic              copi;
  logic              ncs;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
`ifdef SPI_FRAME_ERR_EN
  logic              frame_err;
  logic [7:0]        err_count;
`endif

`ifdef SPI_FRAME_ERR_EN
  modport slave (
    input  sclk, copi, ncs,
    output wr_valid, wr_addr, wr_data, busy, frame_err, err_count
  );
  modport master (
    output sclk, copi, ncs,
    input  wr_valid, wr_addr, wr_data, busy, frame_err, err_count
  );
`else
  modport slave (
    input  sclk, copi, ncs,
    output wr_valid, wr_addr, wr_data, busy
  );
  modport master (
    output sclk, copi, ncs,
    input  wr_valid, wr_addr, wr_data, busy
  );
`endif

endinterface

// File: rtl/sync_edge.sv
// ---------------------------------------------------------------------------
// sync_edge
// Multi-flop synchronizer for one asynchronous pin, plus one history flop
// for rising/falling edge detection on the synchronized level.
//   clk     : system clock
//   rst     : synchronous active-high reset (chain loads RESET_VAL)
//   pin_i   : raw asynchronous input
//   level_o : synchronized level
//   rise_o  : one-cycle pulse on synchronized 0->1
//   fall_o  : one-cycle pulse on synchronized 1->0
// ---------------------------------------------------------------------------
module sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Synchronizer chain and edge-history flop
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      hist_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~hist_q;
  assign fall_o  = ~level_o & hist_q;

endmodule

// File: rtl/spi_frame_rx.sv
// ---------------------------------------------------------------------------
// spi_frame_rx
// SPI mode-0 frame receiver. Synchronizes SCLK/COPI/nCS into clk, shifts in
// MSB-first frames (R/W, 7-bit address, 8-bit data) and issues a one-cycle
// register write strobe for each valid write frame.
// Ports:
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : spi_frame_rx_if.slave (pins in; wr_valid/wr_addr/wr_data/busy out,
//         plus frame_err/err_count when SPI_FRAME_ERR_EN is defined)
// Optional feature macro: SPI_FRAME_ERR_EN (abort pulse + saturating count).
// All outputs are registered.
// ---------------------------------------------------------------------------
module spi_frame_rx
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4,
  parameter int FRAME_BITS  = spi_pkg::FRAME_BITS
) (
  input  logic          clk,
  input  logic          rst,
  spi_frame_rx_if.slave bus
);

  localparam logic [4:0] CNT_FULL  = 5'(FRAME_BITS);
  localparam logic [4:0] CNT_SAT   = 5'(FRAME_BITS + 1);
  localparam logic [2:0] WARM_DONE = 3'(SYNC_STAGES + 1);
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MAX_ADDR);

  // Synchronized pins
  logic sclk_level_s, sclk_rise_s, sclk_fall_s;
  logic ncs_level_s, ncs_rise_s, ncs_fall_s;
  logic copi_level_s, copi_rise_s, copi_fall_s;
  logic unused_edges_s;

  // FSM and datapath state
  spi_state_e            state_q, state_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [2:0]            warm_q;
  logic                  armed_q;

  // Decode of the completed frame
  logic              frame_start_s;
  logic              len_ok_s;
  logic              is_write_s;
  logic              addr_ok_s;
  logic [ADDR_W-1:0] addr_s;
  logic [DATA_W-1:0] data_s;
  logic              accept_s;

  // Registered outputs
  logic              wr_valid_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              busy_q;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .pin_i(bus.sclk),
    .level_o(sclk_level_s), .rise_o(sclk_rise_s), .fall_o(sclk_fall_s)
  );

  // nCS idles high, so its chain resets to 1
  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst(rst), .pin_i(bus.ncs),
    .level_o(ncs_level_s), .rise_o(ncs_rise_s), .fall_o(ncs_fall_s)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst(rst), .pin_i(bus.copi),
    .level_o(copi_level_s), .rise_o(copi_rise_s), .fall_o(copi_fall_s)
  );

  // Only the COPI level and the SCLK rising edge are consumed
  assign unused_edges_s = copi_rise_s ^ copi_fall_s ^ sclk_fall_s ^ sclk_level_s;

  // After reset the nCS chain holds a fake "high" that can decay into a fake
  // falling edge if the pin is really low (reset mid-frame). The receiver is
  // armed only once the chain carries real samples and shows nCS high, so a
  // frame already in flight at reset release is ignored until nCS rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      warm_q  <= 3'd0;
      armed_q <= 1'b0;
    end else begin
      if (warm_q != WARM_DONE) begin
        warm_q <= warm_q + 3'd1;
      end else begin
        warm_q <= warm_q;
      end
      armed_q <= armed_q | ((warm_q == WARM_DONE) & ncs_level_s);
    end
  end

  assign frame_start_s = ncs_fall_s & armed_q;

  // Next-state logic: FSM, bit counter, shift register
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        if (frame_start_s) begin
          state_d = SHIFT;
          cnt_d   = 5'd0;
          shift_d = {FRAME_BITS{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (ncs_rise_s) begin
          state_d = CHECK;
        end else if (sclk_rise_s && !ncs_level_s) begin
          // Bits past the frame length only bump the (saturating) counter
          if (cnt_q < CNT_FULL) begin
            shift_d = {shift_q[FRAME_BITS-2:0], copi_level_s};
          end else begin
            shift_d = shift_q;
          end
          if (cnt_q < CNT_SAT) begin
            cnt_d = cnt_q + 5'd1;
          end else begin
            cnt_d = cnt_q;
          end
        end else begin
          state_d = SHIFT;
        end
      end
      CHECK: begin
        // A new frame may begin while the previous one is being judged
        if (frame_start_s) begin
          state_d = SHIFT;
          cnt_d   = 5'd0;
          shift_d = {FRAME_BITS{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 5'd0;
        shift_d = {FRAME_BITS{1'b0}};
      end
    endcase
  end

  // FSM and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      shift_q <= {FRAME_BITS{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  assign is_write_s = shift_q[FRAME_BITS-1];
  assign addr_s     = shift_q[FRAME_BITS-2 -: ADDR_W];
  assign data_s     = shift_q[DATA_W-1:0];
  assign len_ok_s   = (cnt_q == CNT_FULL);
  assign addr_ok_s  = (addr_s <= ADDR_LIMIT);
  assign accept_s   = (state_q == CHECK) & len_ok_s & is_write_s & addr_ok_s;

  // Write strobe, held write address/data and busy flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_valid_q <= 1'b0;
      wr_addr_q  <= {ADDR_W{1'b0}};
      wr_data_q  <= {DATA_W{1'b0}};
      busy_q     <= 1'b0;
    end else begin
      wr_valid_q <= accept_s;
      if (accept_s) begin
        wr_addr_q <= addr_s;
        wr_data_q <= data_s;
      end else begin
        wr_addr_q <= wr_addr_q;
        wr_data_q <= wr_data_q;
      end
      busy_q <= (state_d == SHIFT);
    end
  end

  assign bus.wr_valid = wr_valid_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.busy     = busy_q;

`ifdef SPI_FRAME_ERR_EN
  // Read frames of the right length are not aborts, whatever their address
  logic       abort_s;
  logic       frame_err_q;
  logic [7:0] err_count_q;

  assign abort_s = (state_q == CHECK) & (~len_ok_s | (is_write_s & ~addr_ok_s));

  // Abort pulse and saturating abort counter
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err_q <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      frame_err_q <= abort_s;
      if (abort_s) begin
        err_count_q <= sat_inc8(err_count_q);
      end else begin
        err_count_q <= err_count_q;
      end
    end
  end

  assign bus.frame_err = frame_err_q;
  assign bus.err_count = err_count_q;
`endif

endmodule

// File: tb/tb_spi_frame_rx.sv
// ---------------------------------------------------------------------------
// tb_spi_frame_rx
// Self-checking bench for spi_frame_rx: a table of frames with expected
// strobes (scoreboard queue) and held outputs, plus hand-written sequences
// for reset mid-frame and error-counter saturation (SPI_FRAME_ERR_EN).
// ---------------------------------------------------------------------------
module tb_spi_frame_rx;
  import spi_pkg::*;

  localparam int SYNC = 2;
  localparam int MAXA = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_frame_rx_if bus ();

  spi_frame_rx #(.SYNC_STAGES(SYNC), .MAX_ADDR(MAXA), .FRAME_BITS(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [6:0] addr;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [31:0] bits;
    int          nbits;
    int          gap;
    bit          strobe;
    bit          check;
    logic [6:0]  addr;   // expected held address after the frame
    logic [7:0]  data;   // expected held data after the frame
    int          errs;   // expected abort count after the frame
  } vec_t;

  exp_t sbq[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int busy_bad = 0;
  int err_pulses = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Strobe monitor: every wr_valid cycle must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.wr_valid !== 1'b0) begin
      if (sbq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_strobe: got wr_valid=%b addr=0x%0h data=0x%0h expected no strobe",
                 bus.wr_valid, bus.wr_addr, bus.wr_data);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("strobe_addr", 32'(bus.wr_addr), 32'(e.addr));
        chk("strobe_data", 32'(bus.wr_data), 32'(e.data));
        chk("strobe_latency", 32'(cyc - rise_cyc), 32'(SYNC + 2));
      end
    end
  end

`ifdef SPI_FRAME_ERR_EN
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.frame_err === 1'b1) err_pulses++;
  end
`endif

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One mode-0 bit: data set while SCLK low, sampled on the rising edge
  task automatic clock_bit(input logic b, input int half);
    bus.copi = b;
    wait_clk(half);
    bus.sclk = 1'b1;
    if (bus.busy !== 1'b1) busy_bad++;
    wait_clk(half);
    bus.sclk = 1'b0;
  endtask

  task automatic send(input logic [31:0] bits, input int n, input int half);
    bus.ncs = 1'b0;
    wait_clk(half);
    for (int i = n - 1; i >= 0; i--) clock_bit(bits[i], half);
    wait_clk(half);
    bus.ncs = 1'b1;
    rise_cyc = cyc;
  endtask

  vec_t vt[7];

  initial begin
    vt[0] = '{32'h8455,  16, 20, 1'b1, 1'b1, 7'd4, 8'h55, 0};
    vt[1] = '{32'h80F0,  16,  4, 1'b1, 1'b0, 7'd0, 8'hF0, 0};
    vt[2] = '{32'h810F,  16, 20, 1'b1, 1'b1, 7'd1, 8'h0F, 0};
    vt[3] = '{32'h0233,  16, 20, 1'b0, 1'b1, 7'd1, 8'h0F, 0};
    vt[4] = '{32'h0845,  12, 20, 1'b0, 1'b1, 7'd1, 8'h0F, 1};
    vt[5] = '{32'h84551, 20, 20, 1'b0, 1'b1, 7'd1, 8'h0F, 2};
    vt[6] = '{32'h87AA,  16, 20, 1'b0, 1'b1, 7'd1, 8'h0F, 3};

    bus.sclk = 1'b0;
    bus.copi = 1'b0;
    bus.ncs  = 1'b1;
    rst      = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(10);

    chk("reset_wr_valid", 32'(bus.wr_valid), 32'd0);
    chk("reset_wr_addr",  32'(bus.wr_addr),  32'd0);
    chk("reset_wr_data",  32'(bus.wr_data),  32'd0);
    chk("reset_busy",     32'(bus.busy),     32'd0);
`ifdef SPI_FRAME_ERR_EN
    chk("reset_err_count", 32'(bus.err_count), 32'd0);
    chk("reset_frame_err", 32'(bus.frame_err), 32'd0);
`endif

    for (int v = 0; v < 7; v++) begin
      if (vt[v].strobe) sbq.push_back('{vt[v].addr, vt[v].data});
      busy_bad = 0;
      send(vt[v].bits, vt[v].nbits, 10);
      wait_clk(vt[v].gap);
      if (vt[v].check) begin
        chk($sformatf("v%0d_busy_in_frame", v), 32'(busy_bad), 32'd0);
        chk($sformatf("v%0d_busy_idle", v), 32'(bus.busy), 32'd0);
        chk($sformatf("v%0d_hold_addr", v), 32'(bus.wr_addr), 32'(vt[v].addr));
        chk($sformatf("v%0d_hold_data", v), 32'(bus.wr_data), 32'(vt[v].data));
        chk($sformatf("v%0d_sb_drained", v), 32'(sbq.size()), 32'd0);
`ifdef SPI_FRAME_ERR_EN
        chk($sformatf("v%0d_err_count", v), 32'(bus.err_count), 32'(vt[v].errs));
        chk($sformatf("v%0d_err_pulses", v), 32'(err_pulses), 32'(vt[v].errs));
`endif
      end
    end

    // Reset in the middle of 0x8399: the remaining bits must not form a frame
    bus.ncs = 1'b0;
    wait_clk(10);
    for (int i = 15; i >= 8; i--) clock_bit(1'(16'h8399 >> i), 10);
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    chk("rst_mid_addr", 32'(bus.wr_addr), 32'd0);
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    for (int i = 7; i >= 0; i--) clock_bit(1'(16'h8399 >> i), 10);
    wait_clk(10);
    bus.ncs = 1'b1;
    wait_clk(20);
    chk("rst_tail_data", 32'(bus.wr_data), 32'd0);
`ifdef SPI_FRAME_ERR_EN
    chk("rst_tail_err_count", 32'(bus.err_count), 32'd0);
`endif
    sbq.push_back('{7'd2, 8'h11});
    send(32'h8211, 16, 10);
    wait_clk(20);
    chk("post_rst_addr", 32'(bus.wr_addr), 32'd2);
    chk("post_rst_data", 32'(bus.wr_data), 32'h11);
    chk("post_rst_sb_drained", 32'(sbq.size()), 32'd0);
`ifdef SPI_FRAME_ERR_EN
    chk("post_rst_err_count", 32'(bus.err_count), 32'd0);

    // 260 one-bit frames: counter must stick at 255
    for (int k = 0; k < 260; k++) begin
      send(32'h1, 1, 4);
      wait_clk(6);
    end
    wait_clk(10);
    chk("sat_err_count", 32'(bus.err_count), 32'd255);
    chk("sat_err_pulses", 32'(err_pulses), 32'd263);
`endif

    wait_clk(20);
    chk("end_sb_empty", 32'(sbq.size()), 32'd0);
    chk("end_hold_addr", 32'(bus.wr_addr), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
